// File: rtl/ssd_bcd_scan_driver.sv
// Binary-to-BCD conversion (sequential double dabble) feeding a 4-digit
// multiplexed 7-segment display with active-low anodes and segments.
module ssd_bcd_scan_driver #(
  parameter int IN_W         = 13,
  parameter int REFRESH_BITS = 18
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] value,
  input  logic            blank_lz,
  output logic [3:0]      anode,
  output logic [6:0]      seg,
  output logic [15:0]     bcd,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(IN_W - 1);

  state_t                  state_q, state_d;
  logic [IN_W-1:0]         src_q, src_d;
  logic [IN_W-1:0]         last_val_q, last_val_d;
  logic [15:0]             scratch_q, scratch_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [15:0]             bcd_q, bcd_d;
  logic                    busy_q, busy_d;
  logic [REFRESH_BITS-1:0] scan_q, scan_d;
  logic [3:0]              anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;

  logic [15:0]             adj;
  logic [1:0]              digit_sel;
  logic [3:0]              digit_nib;
  logic                    digit_blank;

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
  function automatic logic [15:0] add3_nibbles(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'd0:    c = 7'b0000001;
      4'd1:    c = 7'b1001111;
      4'd2:    c = 7'b0010010;
      4'd3:    c = 7'b0000110;
      4'd4:    c = 7'b1001100;
      4'd5:    c = 7'b0100100;
      4'd6:    c = 7'b0100000;
      4'd7:    c = 7'b0001111;
      4'd8:    c = 7'b0000000;
      4'd9:    c = 7'b0000100;
      default: c = 7'b1111111;
    endcase
    return c;
  endfunction

  // A digit is a leading zero when it and every more significant digit are zero.
  function automatic logic is_leading_zero(input logic [15:0] b, input logic [1:0] d);
    logic lz;
    case (d)
      2'd1:    lz = (b[15:4] == 12'd0);
      2'd2:    lz = (b[15:8] == 8'd0);
      2'd3:    lz = (b[15:12] == 4'd0);
      default: lz = 1'b0;
    endcase
    return lz;
  endfunction

  assign adj = add3_nibbles(scratch_q);

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    last_val_d = last_val_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (value != last_val_q) begin
          src_d      = value;
          last_val_d = value;
          scratch_d  = 16'd0;
          cnt_d      = 4'd0;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {adj[14:0], src_q[IN_W-1]};
        src_d     = src_q << 1;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = scratch_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Scan path reads only the committed bcd register, never the scratch.
  always_comb begin
    scan_d      = scan_q + REFRESH_BITS'(1);
    digit_sel   = scan_q[REFRESH_BITS-1 -: 2];
    digit_nib   = 4'd0;
    case (digit_sel)
      2'd0:    digit_nib = bcd_q[3:0];
      2'd1:    digit_nib = bcd_q[7:4];
      2'd2:    digit_nib = bcd_q[11:8];
      default: digit_nib = bcd_q[15:12];
    endcase
    digit_blank = blank_lz && is_leading_zero(bcd_q, digit_sel);
    if (digit_blank) begin
      anode_d = 4'b1111;
      seg_d   = 7'b1111111;
    end else begin
      anode_d = ~(4'b0001 << digit_sel);
      seg_d   = seg_code(digit_nib);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      src_q      <= '0;
      last_val_q <= '0;
      scratch_q  <= 16'd0;
      cnt_q      <= 4'd0;
      bcd_q      <= 16'd0;
      busy_q     <= 1'b0;
      scan_q     <= '0;
      anode_q    <= 4'b1111;
      seg_q      <= 7'b1111111;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      last_val_q <= last_val_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
      scan_q     <= scan_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign bcd   = bcd_q;
  assign busy  = busy_q;

endmodule
